// File: rtl/imem_loader.sv
// Instruction-memory program loader: consumes a byte stream (16-bit LE word
// count header, then LE 32-bit words), writes words sequentially, holds the CPU.
module imem_loader #(
  parameter int          DEPTH     = 32,
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter int          CNT_W     = 16
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic [7:0]       i_in_data,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  output logic             o_mem_we,
  output logic [31:0]      o_mem_addr,
  output logic [31:0]      o_mem_wdata,
  output logic             o_cpu_hold,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_err,
  output logic [CNT_W-1:0] o_words_loaded
);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR0, S_HDR1, S_DATA, S_LAST, S_DONE, S_ERR
  } state_t;

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  state_t           r_state;
  logic             r_in_ready, r_mem_we, r_cpu_hold, r_busy, r_done, r_err;
  logic [31:0]      r_mem_addr, r_mem_wdata;
  logic [CNT_W-1:0] r_words_loaded, r_count, r_word_idx;
  logic [1:0]       r_byte_idx;
  logic [23:0]      r_word;

  logic             w_xfer;
  logic [CNT_W-1:0] w_hdr_count;
  logic             w_last_word;
  logic [31:0]      w_word_addr;

  assign w_xfer      = i_in_valid & r_in_ready;
  assign w_hdr_count = CNT_W'({i_in_data, r_count[7:0]});
  assign w_last_word = (r_word_idx == r_count - CNT_W'(1));
  assign w_word_addr = BASE_ADDR + (32'(r_word_idx) << 2);

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state        <= S_IDLE;
      r_in_ready     <= 1'b0;
      r_mem_we       <= 1'b0;
      r_mem_addr     <= BASE_ADDR;
      r_mem_wdata    <= '0;
      r_cpu_hold     <= 1'b1;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_err          <= 1'b0;
      r_words_loaded <= '0;
      r_count        <= '0;
      r_word_idx     <= '0;
      r_byte_idx     <= '0;
      r_word         <= '0;
    end else begin
      r_mem_we <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE, S_ERR: begin
          if (i_start) begin
            r_state        <= S_HDR0;
            r_in_ready     <= 1'b1;
            r_busy         <= 1'b1;
            r_cpu_hold     <= 1'b1;
            r_done         <= 1'b0;
            r_err          <= 1'b0;
            r_words_loaded <= '0;
            r_byte_idx     <= '0;
            r_word_idx     <= '0;
          end
        end
        S_HDR0: begin
          if (w_xfer) begin
            r_count <= CNT_W'(i_in_data);
            r_state <= S_HDR1;
          end
        end
        S_HDR1: begin
          if (w_xfer) begin
            r_count <= w_hdr_count;
            if (w_hdr_count == '0) begin
              r_state    <= S_DONE;
              r_in_ready <= 1'b0;
              r_busy     <= 1'b0;
              r_done     <= 1'b1;
              r_cpu_hold <= 1'b0;
            end else if (w_hdr_count > DEPTH_C) begin
              r_state    <= S_ERR;
              r_in_ready <= 1'b0;
              r_busy     <= 1'b0;
              r_err      <= 1'b1;
            end else begin
              r_state <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (w_xfer) begin
            // Bytes 0..2 shift down so byte 0 ends in the low lane.
            r_word     <= {i_in_data, r_word[23:8]};
            r_byte_idx <= r_byte_idx + 2'd1;
            if (r_byte_idx == 2'd3) begin
              r_mem_we       <= 1'b1;
              r_mem_wdata    <= {i_in_data, r_word};
              r_mem_addr     <= w_word_addr;
              r_words_loaded <= r_words_loaded + CNT_W'(1);
              r_word_idx     <= r_word_idx + CNT_W'(1);
              if (w_last_word) begin
                r_state    <= S_LAST;
                r_in_ready <= 1'b0;
              end
            end
          end
        end
        S_LAST: begin
          r_state    <= S_DONE;
          r_busy     <= 1'b0;
          r_done     <= 1'b1;
          r_cpu_hold <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_in_ready     = r_in_ready;
  assign o_mem_we       = r_mem_we;
  assign o_mem_addr     = r_mem_addr;
  assign o_mem_wdata    = r_mem_wdata;
  assign o_cpu_hold     = r_cpu_hold;
  assign o_busy         = r_busy;
  assign o_done         = r_done;
  assign o_err          = r_err;
  assign o_words_loaded = r_words_loaded;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: a model expands each stream into expected
// memory writes; a monitor pops them on every mem_we pulse.
module tb_imem_loader;
  localparam int          DEPTH = 32;
  localparam logic [31:0] BASE  = 32'h0;

  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, in_valid = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_ready, mem_we, cpu_hold, busy, done, err;
  logic [31:0] mem_addr, mem_wdata;
  logic [15:0] words_loaded;

  imem_loader #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .CNT_W(16)) dut (
    .i_clk(clk), .i_reset(rst_n), .i_start(start), .i_in_data(in_data),
    .i_in_valid(in_valid), .o_in_ready(in_ready), .o_mem_we(mem_we),
    .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata), .o_cpu_hold(cpu_hold),
    .o_busy(busy), .o_done(done), .o_err(err), .o_words_loaded(words_loaded));

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; logic [31:0] data; logic [15:0] wl; } exp_t;
  exp_t exp_q[$];
  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_write: addr %h data %h expected none", mem_addr, mem_wdata);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("wr_addr", mem_addr, e.addr);
        chk("wr_data", mem_wdata, e.data);
        chk("wr_words_loaded", 32'(words_loaded), 32'(e.wl));
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int n = 0;
    if (gaps) repeat ($urandom_range(0, 3)) @(negedge clk);
    in_valid = 1'b1; in_data = b;
    while (in_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) chk("byte_accept_timeout", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic chk_reset_vals();
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_mem_we", 32'(mem_we), 0);
    chk("rst_mem_addr", mem_addr, BASE);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_cpu_hold", 32'(cpu_hold), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_words_loaded", 32'(words_loaded), 0);
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("start_busy", 32'(busy), 1);
    chk("start_cpu_hold", 32'(cpu_hold), 1);
    chk("start_done_clr", 32'(done), 0);
    chk("start_err_clr", 32'(err), 0);
    chk("start_wl_clr", 32'(words_loaded), 0);
    chk("start_in_ready", 32'(in_ready), 1);
  endtask

  // Full load: model the expected writes from the stream, drive it, check the outcome.
  task automatic run_load(input logic [7:0] b[$], input bit gaps, input bit mid_start);
    int cnt, nbytes, n;
    bit good;
    cnt  = int'(b[0]) | (int'(b[1]) << 8);
    good = (cnt <= DEPTH);
    nbytes = (good && cnt > 0) ? 2 + 4 * cnt : 2;
    if (good)
      for (int i = 0; i < cnt; i++) begin
        exp_t e;
        e.addr = BASE + 32'(4 * i);
        e.data = {b[2+4*i+3], b[2+4*i+2], b[2+4*i+1], b[2+4*i]};
        e.wl   = 16'(i + 1);
        exp_q.push_back(e);
      end
    pulse_start();
    for (int i = 0; i < nbytes; i++) begin
      send_byte(b[i], gaps);
      if (mid_start && i == 3) begin
        start = 1'b1; @(negedge clk); start = 1'b0;
        chk("mid_start_busy", 32'(busy), 1);
      end
    end
    n = 0;
    while (!(done === 1'b1 || err === 1'b1) && n < 20) begin @(negedge clk); n++; end
    chk("end_done", 32'(done), good ? 1 : 0);
    chk("end_err", 32'(err), good ? 0 : 1);
    chk("end_cpu_hold", 32'(cpu_hold), good ? 0 : 1);
    chk("end_busy", 32'(busy), 0);
    chk("end_words_loaded", 32'(words_loaded), good ? cnt : 0);
    chk("end_pending_writes", exp_q.size(), 0);
    if (good && cnt > 0) chk("end_addr_hold", mem_addr, BASE + 32'(4 * (cnt - 1)));
    // Stream bytes offered after the load must not be consumed.
    in_valid = 1'b1; in_data = 8'hA5;
    repeat (3) begin @(negedge clk); chk("idle_in_ready", 32'(in_ready), 0); end
    in_valid = 1'b0;
  endtask

  logic [7:0] s1[$] = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h30, 8'h00, 8'h13, 8'h81, 8'h50, 8'h00};

  initial begin
    logic [7:0] bq[$];
    repeat (3) @(negedge clk);
    chk_reset_vals();
    rst_n = 1'b1;
    @(negedge clk);

    run_load(s1, 1'b0, 1'b0);
    run_load(s1, 1'b1, 1'b0);
    bq = '{8'h00, 8'h00};
    run_load(bq, 1'b1, 1'b0);
    bq = '{8'h21, 8'h00};
    run_load(bq, 1'b0, 1'b0);
    run_load(s1, 1'b0, 1'b0);

    // Reset mid-load, two bytes into the first word.
    pulse_start();
    for (int i = 0; i < 4; i++) send_byte(s1[i], 1'b0);
    rst_n = 1'b0; #1;
    chk_reset_vals();
    @(negedge clk); rst_n = 1'b1; @(negedge clk);
    run_load(s1, 1'b1, 1'b0);

    run_load(s1, 1'b1, 1'b1);

    // Randomized loads, including over-depth headers.
    for (int k = 0; k < 8; k++) begin
      int c;
      c = $urandom_range(0, DEPTH + 3);
      bq.delete();
      bq.push_back(8'(c)); bq.push_back(8'(c >> 8));
      for (int i = 0; i < 4 * c; i++) bq.push_back(8'($urandom));
      run_load(bq, ($urandom_range(0, 1) == 1), 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
